// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings and counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM_HI = 2'd1,
      HELD   = 2'd2,
      ARM_LO = 2'd3
   } btn_state_t;

   // Bits needed to hold any value 0..max_value, never less than one bit.
   function automatic int cnt_width(input int max_value);
      return (max_value < 2) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_1.sv
// One push-button: 2-flop synchronizer, debounce FSM, auto-repeat timer.
// Latency: level/pulse change 2+DEBOUNCE_CYCLES edges after a stable raw edge is first sampled.
// Backpressure: none; free-running, pulses are single-cycle and cannot be stalled.
module btn_debounce_1
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rel
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES - 1);
   localparam int RW = cnt_width(REPEAT_DELAY);

   // A single stable sample is enough: skip the ARM states entirely.
   localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);
   localparam bit RPT_EN = (REPEAT_DELAY > 0);

   // Reload keeps the pulse spacing at REPEAT_PERIOD; clamped so a period
   // longer than the delay cannot underflow the counter.
   localparam int RELOAD_I = (REPEAT_DELAY > REPEAT_PERIOD) ? (REPEAT_DELAY - REPEAT_PERIOD) : 0;
   localparam int LAST_I   = RPT_EN ? (REPEAT_DELAY - 1) : 0;

   localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [RW-1:0] RPT_LAST   = RW'(LAST_I);
   localparam logic [RW-1:0] RPT_RELOAD = RW'(RELOAD_I);
   localparam logic [RW-1:0] RPT_ONE    = RW'(1);

   logic [1:0]    sync_q;
   logic          sync;
   btn_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          level_d, press_d, rel_d;

   assign sync = sync_q[1];

   // Two-flop synchronizer for the asynchronous raw level.
   always_ff @(posedge clock) begin
      if (reset) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], raw};
   end

   // FSM, counters and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rcnt_q  <= '0;
         level   <= 1'b0;
         press   <= 1'b0;
         rel     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rcnt_q  <= rcnt_d;
         level   <= level_d;
         press   <= press_d;
         rel     <= rel_d;
      end
   end

   // Next-state: count consecutive agreeing samples; any contrary sample restarts.
   // The repeat pulse fires on the edge where rcnt would reach REPEAT_DELAY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      level_d = level;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync) begin
               if (DIRECT) begin
                  state_d = HELD;
                  level_d = 1'b1;
                  press_d = 1'b1;
                  rcnt_d  = '0;
               end else begin
                  state_d = ARM_HI;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         ARM_HI: begin
            if (!sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
               rcnt_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!sync) begin
               if (DIRECT) begin
                  state_d = IDLE;
                  level_d = 1'b0;
                  rel_d   = 1'b1;
               end else begin
                  state_d = ARM_LO;
                  cnt_d   = CNT_ONE;
               end
            end else if (RPT_EN) begin
               if (rcnt_q == RPT_LAST) begin
                  press_d = 1'b1;
                  rcnt_d  = RPT_RELOAD;
               end else begin
                  rcnt_d = rcnt_q + RPT_ONE;
               end
            end
         end
         ARM_LO: begin
            // Returning to HELD leaves rcnt alone so repeat timing carries on.
            if (sync) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels, press/repeat and release pulses.
// Latency: 2+DEBOUNCE_CYCLES edges from first sampling a stable raw edge to level/pulse.
// Backpressure: none; outputs are free-running registered pulses.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   // One fully independent conditioner per button.
   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce_1 #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_debounce (
         .clock (clock),
         .reset (reset),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .press (btn_press[i]),
         .rel   (btn_release[i])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus randomized traffic.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_btn_conditioner;

   localparam int NB = 2;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic          clock;
   logic          reset;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;

   int n_cmp = 0;
   int n_bad = 0;

   btn_conditioner #(
      .N_BTN           (NB),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: what the FSM sees is the raw level two edges late;
   // a level is accepted after D consecutive disagreeing samples; repeat pulses
   // fire after RD, RD+RP, RD+2RP ... ticks spent steadily held.
   logic [NB-1:0] mq1, mq2, m_level, m_press, m_rel, m_prev;
   int            m_run  [NB];
   int            m_hold [NB];

   task automatic model_edge(input logic [NB-1:0] raw, input logic rst);
      m_press = '0;
      m_rel   = '0;
      if (rst) begin
         mq1 = '0; mq2 = '0; m_level = '0; m_prev = '0;
         for (int b = 0; b < NB; b++) begin
            m_run[b]  = 0;
            m_hold[b] = 0;
         end
      end else begin
         for (int b = 0; b < NB; b++) begin
            logic cur;
            cur = mq2[b];
            if (cur != m_level[b]) m_run[b]++;
            else                   m_run[b] = 0;
            if (m_run[b] == D) begin
               m_level[b] = cur;
               if (cur) m_press[b] = 1'b1;
               else     m_rel[b]   = 1'b1;
               m_run[b]  = 0;
               m_hold[b] = 0;
            end else if (m_level[b] && m_prev[b] && cur) begin
               m_hold[b]++;
               if (RD > 0 && m_hold[b] >= RD && ((m_hold[b] - RD) % RP) == 0)
                  m_press[b] = 1'b1;
            end
            m_prev[b] = cur;
         end
         mq2 = mq1;
         mq1 = raw;
      end
   endtask

   // Advance one rising edge, keep the model in lock-step, sample 1 time unit later.
   task automatic tick();
      @(posedge clock);
      model_edge(btn_raw, reset);
      #1;
   endtask

   task automatic settle();
      btn_raw = '0;
      reset   = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      btn_raw = 2'b11;
      for (int e = 1; e <= 3; e++) begin
         tick();
         n_cmp++;
         if ({btn_level, btn_press, btn_release} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset edge %0d: got %b want 000000", e, {btn_level, btn_press, btn_release});
         end
      end
      reset   = 1'b0;
      btn_raw = '0;
   endtask

   task automatic test_clean_press();
      logic [5:0] exp;
      settle();
      btn_raw = 2'b01;
      for (int e = 1; e <= 12; e++) begin
         tick();
         exp = {1'b0, 1'(e >= 6), 1'b0, 1'(e == 6), 2'b00};
         n_cmp++;
         if ({btn_level, btn_press, btn_release} !== exp) begin
            n_bad++;
            $display("FAIL clean_press edge %0d: got %b want %b", e, {btn_level, btn_press, btn_release}, exp);
         end
      end
   endtask

   task automatic test_release();
      logic [5:0] exp;
      btn_raw = 2'b00;
      for (int e = 1; e <= 10; e++) begin
         tick();
         exp = {1'b0, 1'(e < 6), 2'b00, 1'b0, 1'(e == 6)};
         n_cmp++;
         if ({btn_level, btn_press, btn_release} !== exp) begin
            n_bad++;
            $display("FAIL release edge %0d: got %b want %b", e, {btn_level, btn_press, btn_release}, exp);
         end
      end
   endtask

   task automatic test_bounce();
      logic pat [8];
      logic [5:0] exp;
      int presses;
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      presses = 0;
      settle();
      // Final 0->1 is first sampled at edge 5, so acceptance lands on edge 10.
      for (int e = 1; e <= 16; e++) begin
         btn_raw = {1'b0, (e <= 8) ? pat[e-1] : 1'b1};
         tick();
         presses += int'(btn_press[0]);
         exp = {1'b0, 1'(e >= 10), 1'b0, 1'(e == 10), 2'b00};
         n_cmp++;
         if ({btn_level, btn_press, btn_release} !== exp) begin
            n_bad++;
            $display("FAIL bounce edge %0d: got %b want %b", e, {btn_level, btn_press, btn_release}, exp);
         end
      end
      n_cmp++;
      if (presses != 1) begin
         n_bad++;
         $display("FAIL bounce_count: got %0d presses want 1", presses);
      end
   endtask

   task automatic test_repeat();
      logic exp;
      settle();
      btn_raw = 2'b01;
      repeat (6) tick();
      n_cmp++;
      if (btn_press !== 2'b01 || btn_level !== 2'b01) begin
         n_bad++;
         $display("FAIL repeat_accept: got press %b level %b want 01 01", btn_press, btn_level);
      end
      for (int k = 1; k <= 30; k++) begin
         tick();
         exp = (k >= RD) && (((k - RD) % RP) == 0);
         n_cmp++;
         if (btn_press !== {1'b0, exp} || btn_level !== 2'b01 || btn_release !== 2'b00) begin
            n_bad++;
            $display("FAIL repeat +%0d: got press %b level %b rel %b want press 0%b level 01 rel 00",
                     k, btn_press, btn_level, btn_release, exp);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [5:0] exp;
      btn_raw = 2'b01;
      reset   = 1'b1;
      tick();
      n_cmp++;
      if ({btn_level, btn_press, btn_release} !== 6'b0) begin
         n_bad++;
         $display("FAIL mid_hold_reset_edge: got %b want 000000", {btn_level, btn_press, btn_release});
      end
      reset = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         exp = {1'b0, 1'(e >= 6), 1'b0, 1'(e == 6), 2'b00};
         n_cmp++;
         if ({btn_level, btn_press, btn_release} !== exp) begin
            n_bad++;
            $display("FAIL mid_hold edge %0d: got %b want %b", e, {btn_level, btn_press, btn_release}, exp);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic l, p;
      settle();
      btn_raw = 2'b11;
      for (int e = 1; e <= 8; e++) begin
         tick();
         l = (e >= 6);
         p = (e == 6);
         n_cmp++;
         if ({btn_level, btn_press, btn_release} !== {l, l, p, p, 2'b00}) begin
            n_bad++;
            $display("FAIL simultaneous edge %0d: got %b want %b", e,
                     {btn_level, btn_press, btn_release}, {l, l, p, p, 2'b00});
         end
      end
   endtask

   task automatic test_random();
      int bouncy;
      settle();
      for (int c = 0; c < 1500; c++) begin
         bouncy = ((c / 100) % 2 == 0) ? 3 : 25;
         for (int b = 0; b < NB; b++)
            if ($urandom_range(bouncy - 1, 0) == 0) btn_raw[b] = ~btn_raw[b];
         reset = ($urandom_range(249, 0) == 0);
         tick();
         n_cmp++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
            n_bad++;
            $display("FAIL random cycle %0d: got %b want %b", c,
                     {btn_level, btn_press, btn_release}, {m_level, m_press, m_rel});
         end
         n_cmp++;
         if ((btn_press & btn_release) !== 2'b00) begin
            n_bad++;
            $display("FAIL random_exclusive cycle %0d: got press&release %b want 00", c, btn_press & btn_release);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      btn_raw = '0;
      test_reset();
      test_clean_press();
      test_release();
      test_bounce();
      test_repeat();
      test_reset_mid_hold();
      test_simultaneous();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
